// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the scoreboarded register file
package regfile_pkg;

  localparam int NREGS_DEF  = 17;
  localparam int PEND_W_DEF = 2;
  localparam int IDX_W_DEF  = $clog2(NREGS_DEF);
  localparam int WB_MAX     = 8;
  localparam int CNT_W      = 4;

  typedef logic [IDX_W_DEF-1:0]  reg_idx_t;
  typedef logic [PEND_W_DEF-1:0] pend_t;
  typedef logic [CNT_W-1:0]      wb_cnt_t;

  // Number of writeback ports hitting one register this cycle.
  function automatic wb_cnt_t wb_match_count(input logic [WB_MAX-1:0] hits);
    wb_cnt_t n;
    n = '0;
    for (int i = 0; i < WB_MAX; i++) begin
      n = n + wb_cnt_t'(hits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pend_counter.sv
// rtl/pend_counter.sv - per-register in-flight writer counter, clamps at 0 and at max
module pend_counter #(
  parameter int PEND_W = 2,
  parameter int DEC_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic [DEC_W-1:0]  dec_cnt,
  input  logic              clr,
  output logic [PEND_W-1:0] cnt,
  output logic [PEND_W-1:0] post_wb,
  output logic              underflow
);

  localparam int SW = ((PEND_W > DEC_W) ? PEND_W : DEC_W) + 1;
  localparam logic [SW-1:0] MAX_W = SW'((2 ** PEND_W) - 1);

  logic [SW-1:0] cur_w, dec_w, up_w, net_w;

  // post_wb ignores this cycle's increment so it can feed issue gating without a loop.
  always_comb begin
    cur_w     = SW'(cnt);
    dec_w     = SW'(dec_cnt);
    up_w      = cur_w + SW'(inc);
    underflow = up_w < dec_w;
    net_w     = underflow ? '0 : (up_w - dec_w);
    post_wb   = (cur_w >= dec_w) ? PEND_W'(cur_w - dec_w) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (net_w > MAX_W) begin
      cnt <= '1;
    end else begin
      cnt <= PEND_W'(net_w);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with writeback bypass and pending-writer scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int NREGS    = 17,
  parameter int DATA_W   = 64,
  parameter int RD_PORTS = 3,
  parameter int WB_PORTS = 1,
  parameter int PEND_W   = 2,
  parameter int IDX_W    = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [RD_PORTS-1:0]          rd_valid,
  input  logic [RD_PORTS*IDX_W-1:0]    rd_idx,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_busy,
  input  logic                         iss_valid,
  input  logic                         iss_dst_valid,
  input  logic [IDX_W-1:0]             iss_dst,
  output logic                         iss_ready,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]    wb_idx,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
  input  logic                         flush,
  output logic                         busy_any,
  output logic                         err
);

  localparam logic [IDX_W:0] NREGS_L = (IDX_W + 1)'(NREGS);

  function automatic logic in_range(input logic [IDX_W-1:0] i);
    return {1'b0, i} < NREGS_L;
  endfunction

  logic [DATA_W-1:0]             regs [NREGS];
  logic [NREGS-1:0][PEND_W-1:0]  pend;
  logic [NREGS-1:0][PEND_W-1:0]  post_wb;
  logic [NREGS-1:0]              underflow;
  logic [WB_PORTS-1:0]           wb_ok;
  logic [IDX_W-1:0]              ridx;
  logic                          iss_fire, dst_full, bad_claim, bad_wb;

  always_comb begin
    wb_ok = '0;
    for (int w = 0; w < WB_PORTS; w++) begin
      wb_ok[w] = wb_valid[w] && in_range(wb_idx[w*IDX_W +: IDX_W]);
    end
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    logic [WB_MAX-1:0] hits;
    wb_cnt_t           dec;
    logic              inc;

    always_comb begin
      hits = '0;
      for (int w = 0; w < WB_PORTS; w++) begin
        hits[w] = wb_ok[w] && (wb_idx[w*IDX_W +: IDX_W] == IDX_W'(r));
      end
    end

    assign dec = wb_match_count(hits);
    assign inc = iss_fire && iss_dst_valid && (iss_dst == IDX_W'(r));

    pend_counter #(.PEND_W(PEND_W), .DEC_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc),
      .dec_cnt   (dec),
      .clr       (flush),
      .cnt       (pend[r]),
      .post_wb   (post_wb[r]),
      .underflow (underflow[r])
    );
  end

  // Later ports overwrite earlier ones, so the highest matching wb port wins.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ridx    = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      ridx = rd_idx[p*IDX_W +: IDX_W];
      if (in_range(ridx)) begin
        rd_data[p*DATA_W +: DATA_W] = regs[ridx];
        for (int w = 0; w < WB_PORTS; w++) begin
          if (wb_ok[w] && (wb_idx[w*IDX_W +: IDX_W] == ridx)) begin
            rd_data[p*DATA_W +: DATA_W] = wb_data[w*DATA_W +: DATA_W];
          end
        end
        rd_busy[p] = rd_valid[p] && (post_wb[ridx] != '0);
      end
    end
  end

  always_comb begin
    dst_full  = iss_dst_valid && in_range(iss_dst) && (post_wb[iss_dst] == '1);
    iss_ready = !(|rd_busy) && !dst_full;
    iss_fire  = iss_valid && iss_ready && !flush;
    bad_claim = iss_fire && iss_dst_valid && !in_range(iss_dst);
    bad_wb    = |(wb_valid & ~wb_ok);
  end

  always_comb begin
    busy_any = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      busy_any = busy_any | (pend[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (flush) begin
      err <= 1'b0;
    end else if ((|underflow) || bad_claim || bad_wb) begin
      err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int w = 0; w < WB_PORTS; w++) begin
        if (wb_ok[w]) begin
          regs[wb_idx[w*IDX_W +: IDX_W]] <= wb_data[w*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with an integrated pending-writer scoreboard, replacing the core's single-bit `reg_occupies` vector and flat `regs` array. It sits between decode and the data-fetch/schedule stage: it supplies operand values with same-cycle writeback bypass, gates issue on source and destination hazards, and tracks multiple in-flight writers per register with saturating counters. Writeback ports from the WB stage retire writers and update architectural state.

## Interface
Parameters:
- `NREGS`, 17: number of architectural registers.
- `DATA_W`, 64: register width.
- `RD_PORTS`, 3: source-operand read ports.
- `WB_PORTS`, 1: writeback ports.
- `PEND_W`, 2: pending-counter width. A register allows at most 2^PEND_W−1 in-flight writers.
- `IDX_W`, $clog2(NREGS): register index width.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rd_valid`  in  RD_PORTS  source port p is in use.
- `rd_idx`  in  RD_PORTS*IDX_W  source index per port.
- `rd_data`  out  RD_PORTS*DATA_W  operand value, bypassed (combinational).
- `rd_busy`  out  RD_PORTS  source still has pending writers after this cycle's writebacks (combinational).
- `iss_valid`  in  1  decode offers a micro-op.
- `iss_dst_valid`  in  1  micro-op writes a register.
- `iss_dst`  in  IDX_W  destination index.
- `iss_ready`  out  1  issue permitted this cycle (combinational).
- `wb_valid`  in  WB_PORTS  writeback strobe per port.
- `wb_idx`  in  WB_PORTS*IDX_W  writeback register index.
- `wb_data`  in  WB_PORTS*DATA_W  writeback value.
- `flush`  in  1  discard all in-flight writers.
- `busy_any`  out  1  OR of all pending counters being nonzero (registered).
- `err`  out  1  sticky underflow/overflow flag (registered).

## Operation
- `pend[r]` (PEND_W bits) counts the writers of register r that have issued and not yet written back.
- Issue fires when `iss_valid && iss_ready && !flush`.
- `iss_ready` = no valid `rd` port busy AND (`!iss_dst_valid` OR the destination counter after writeback is below 2^PEND_W−1).
- On issue fire with `iss_dst_valid`, `pend[iss_dst]` increments.
- On each `wb_valid` port, `regs[wb_idx]` is written and `pend[wb_idx]` decrements once per port.
- Net counter update per register per cycle = +issue − (number of matching wb ports).
  - Issue and writeback to the same register in one cycle leave the counter unchanged.
- Multiple wb ports hitting the same index in one cycle: the highest port number wins the data, and the counter decrements by the match count.
- Underflow (a decrement below 0) clamps the counter to 0 and sets `err`. Increment at saturation cannot occur, because `iss_ready` blocks it.
- Bypass: when `rd_idx` matches a valid writeback this cycle, `rd_data` returns that port's `wb_data` (highest matching port). Otherwise it returns `regs`.
- `rd_busy[p]` = `rd_valid[p]` && (`pend` − matching wb count) ≠ 0.
- `flush`: all counters and `err` clear at the next edge and issue is ignored. Writebacks in the same cycle still update `regs`. The producer guarantees no stale writebacks after a flush.
- Index ≥ NREGS on any port: reads return 0 and are not busy. Writes and claims are dropped, and `err` is set.

## Timing
- Reset (asynchronous assert, synchronous-edge deassert): `regs` = 0, `pend` = 0, `err` = 0, `busy_any` = 0.
  - With inputs idle after reset: `rd_data` = 0, `rd_busy` = 0, `iss_ready` = 1.
- Reset asserted mid-operation discards all state immediately.
- Read-to-data latency: 0 cycles (combinational). Writeback-to-visible-in-`regs`: 1 edge. The bypass covers the gap.
- A dependent micro-op may issue in the same cycle its producer writes back.
- `busy_any` and `err` reflect state after the edge: 1-cycle latency.

## Structure
- Package `regfile_pkg`: `reg_idx_t`, `pend_t`, and the helper function `wb_match_count`. `GLB_REG_NUM` stays in `global.svh`.
- Sub-module `pend_counter`: one saturating up/down counter with inc, dec-count, clear, and underflow-flag outputs, generated per register.

## Test plan
- Reset, then read r3 on port 0 -> `rd_data` = 0, `rd_busy` = 0, `iss_ready` = 1.
- Issue dst = r5; next cycle read r5 -> `rd_busy` = 1. Writeback r5 = 0xDEAD in the same cycle as the read -> `rd_data` = 0xDEAD, `rd_busy` = 0.
- With PEND_W = 2, issue three writers to r2 -> fourth issue sees `iss_ready` = 0. Three writebacks return the counter to 0, `busy_any` = 0.
- Same-cycle issue dst = r7 and writeback r7 with pend = 1 -> pend stays 1, and `regs[7]` updated to the wb value.
- WB_PORTS = 2, both ports write r4 (0x11 on port 0, 0x22 on port 1) with pend = 2 -> `regs[4]` = 0x22, pend = 0. Repeat with pend = 1 -> `err` = 1.
- Three pending writers outstanding, assert `flush` together with one issue and one writeback r1 = 0x5 -> all pend = 0, `err` = 0, `regs[1]` = 0x5, no claim recorded.
